// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and the
// result codes reported on status_o.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
    localparam logic [1:0] STATUS_JUMP    = 2'b10;

endpackage

// File: rtl/count_step_detector.sv
// Watches a counter output against a registered previous value.
// Ports: clock_i/reset_i (async high), sample_i (capture count_i),
//   advance_i (track count_i on a legal step), count_i (observed count),
//   step_o (count_i == prev+1, wrapping), jump_o (any other change).
module count_step_detector
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             sample_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             step_o,
    output logic             jump_o
);

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= '0;
        end else if (sample_i || (advance_i && step_o)) begin
            prev_q <= count_i;
        end
    end

    // Wrap from all-ones to zero is a legal single step.
    assign step_o = (count_i == prev_q + WIDTH'(1));
    assign jump_o = !step_o && (count_i != prev_q);

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven initiator for a prescaled counter: preloads the
// prescaler phase, runs until N increments are seen, reports result.
// Ports: clock_i/reset_i (async high); cmd_valid_i/cmd_ready_o with
//   cmd_load_i, cmd_steps_i; counter drives enable_o, write_o, c_val_o;
//   count_i from the counter; busy_o, done_o, status_o, steps_seen_o.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_load_i,
    input  logic [WIDTH-1:0] cmd_steps_i,
    output logic             enable_o,
    output logic             write_o,
    output logic [WIDTH-1:0] c_val_o,
    input  logic [WIDTH-1:0] count_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic [WIDTH-1:0] steps_seen_o
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ?
                        $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    logic [WIDTH-1:0] seen_q, seen_d;
    logic [1:0]       status_q, status_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             sample;
    logic             advance;
    logic             step;
    logic             jump;

    count_step_detector #(
        .WIDTH (WIDTH)
    ) u_det (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .sample_i  (sample),
        .advance_i (advance),
        .count_i   (count_i),
        .step_o    (step),
        .jump_o    (jump)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            load_q   <= '0;
            steps_q  <= '0;
            seen_q   <= '0;
            status_q <= STATUS_OK;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            steps_q  <= steps_d;
            seen_q   <= seen_d;
            status_q <= status_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        steps_d  = steps_q;
        seen_d   = seen_q;
        status_d = status_q;
        tmo_d    = tmo_q;
        sample   = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    load_d   = cmd_load_i;
                    steps_d  = cmd_steps_i;
                    sample   = 1'b1;
                    seen_d   = '0;
                    status_d = STATUS_OK;
                    tmo_d    = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (steps_q != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                advance = 1'b1;
                if (jump) begin
                    status_d = STATUS_JUMP;
                    state_d  = ST_DONE;
                end else if (step) begin
                    // A step clears the idle count, so it beats a timeout.
                    seen_d = seen_q + WIDTH'(1);
                    tmo_d  = '0;
                    if (seen_d == steps_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    if (tmo_q != TMO_LAST) begin
                        tmo_d = tmo_q + TW'(1);
                    end
                    if (tmo_d == TMO_LAST) begin
                        status_d = STATUS_TIMEOUT;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready_o  = (state_q == ST_IDLE) && !reset_i;
    assign enable_o     = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign write_o      = (state_q == ST_LOAD);
    assign c_val_o      = enable_o ? load_q : '0;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign status_o     = status_q;
    assign steps_seen_o = seen_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer driving a behavioural
// prescaled counter (8 cycles per count) or hand-driven count values.
module tb_counter_sequencer;

    typedef struct {
        logic [1:0] status;
        logic [7:0] seen;
        bit         chk_cnt;
        logic [7:0] cnt;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_load = '0;
    logic [7:0] cmd_steps = '0;
    logic       enable;
    logic       write;
    logic [7:0] c_val;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [7:0] seen;

    logic       manual = 1'b0;
    logic [7:0] man_count = '0;
    logic       preset_en = 1'b0;
    logic [7:0] preset_val = '0;
    logic [7:0] m_count = '0;
    logic [2:0] m_phase = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   prev_done = 1'b0;
    exp_t exp_q[$];

    counter_sequencer #(
        .WIDTH          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_load_i   (cmd_load),
        .cmd_steps_i  (cmd_steps),
        .enable_o     (enable),
        .write_o      (write),
        .c_val_o      (c_val),
        .count_i      (count),
        .busy_o       (busy),
        .done_o       (done),
        .status_o     (status),
        .steps_seen_o (seen)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Behavioural prescaled counter: write loads the phase,
    // count advances when the phase wraps from 7.
    always @(posedge clock) begin
        if (preset_en) begin
            m_count <= preset_val;
            m_phase <= '0;
        end else if (enable && write) begin
            m_phase <= c_val[2:0];
        end else if (enable) begin
            if (m_phase == 3'd7) begin
                m_phase <= '0;
                m_count <= m_count + 8'd1;
            end else begin
                m_phase <= m_phase + 3'd1;
            end
        end
    end

    assign count = manual ? man_count : m_count;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every done_o pulse.
    always @(negedge clock) begin
        exp_t e;
        if (done) begin
            chk("done_single", int'(prev_done), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("status", int'(status), int'(e.status));
                chk("steps_seen", int'(seen), int'(e.seen));
                chk("enable_in_done", int'(enable), 0);
                if (e.chk_cnt) begin
                    chk("count", int'(count), int'(e.cnt));
                end
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [7:0] ld, input logic [7:0] st,
                         input exp_t e, output int acc);
        int n = 0;
        exp_q.push_back(e);
        cmd_load  = ld;
        cmd_steps = st;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("accept_wait", 0, 1);
        @(negedge clock);
        acc = cyc;
        cmd_valid = 1'b0;
        chk("load_write_en", int'({write, enable}), 3);
        chk("load_cval", int'(c_val), int'(ld));
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!done) chk("done_wait", 0, 1);
        dc = cyc;
        @(negedge clock);
        chk("enable_after_done", int'(enable), 0);
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic preset(input logic [7:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        @(negedge clock);
        preset_en  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   acc;
        int   dc;
        int   jc;
        logic [7:0] base;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy_done", int'({busy, done}), 0);
        chk("rst_en_wr", int'({enable, write}), 0);
        chk("rst_status_seen", int'({status, seen}), 0);
        chk("rst_cval", int'(c_val), 0);
        @(negedge clock);

        // Load 0, 3 steps from count 0.
        preset(8'd0);
        e = '{status: 2'b00, seen: 8'd3, chk_cnt: 1'b1, cnt: 8'd3};
        issue(8'd0, 8'd3, e, acc);
        wait_done(dc);

        // Load 7, 1 step: increment visible on 2nd RUN cycle.
        e = '{status: 2'b00, seen: 8'd1, chk_cnt: 1'b1, cnt: 8'd4};
        issue(8'd7, 8'd1, e, acc);
        wait_done(dc);
        chk("lat_load7", dc - acc, 3);

        // Wrap 254 -> 255 -> 0 -> 1.
        preset(8'd254);
        e = '{status: 2'b00, seen: 8'd3, chk_cnt: 1'b1, cnt: 8'd1};
        issue(8'd0, 8'd3, e, acc);
        wait_done(dc);

        // Steps 0: load only.
        e = '{status: 2'b00, seen: 8'd0, chk_cnt: 1'b0, cnt: 8'd0};
        issue(8'd2, 8'd0, e, acc);
        wait_done(dc);
        chk("lat_load_only", dc - acc, 1);

        // Timeout: count frozen at 5.
        manual    = 1'b1;
        man_count = 8'd5;
        e = '{status: 2'b01, seen: 8'd0, chk_cnt: 1'b0, cnt: 8'd0};
        issue(8'd0, 8'd2, e, acc);
        wait_done(dc);
        chk("lat_timeout", dc - acc, 16);

        // Jump 6 -> 9 after one legal step.
        man_count = 8'd5;
        e = '{status: 2'b10, seen: 8'd1, chk_cnt: 1'b0, cnt: 8'd0};
        issue(8'd0, 8'd4, e, acc);
        @(negedge clock);
        man_count = 8'd6;
        @(negedge clock);
        man_count = 8'd9;
        jc = cyc;
        wait_done(dc);
        chk("lat_jump", dc - jc, 1);
        manual = 1'b0;

        // Reset mid-RUN with the next command already offered.
        preset(8'd0);
        e = '{status: 2'b00, seen: 8'd3, chk_cnt: 1'b0, cnt: 8'd0};
        issue(8'd0, 8'd3, e, acc);
        cmd_valid = 1'b1;
        repeat (5) @(negedge clock);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_enable", int'(enable), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("postrst_ready", int'(cmd_ready), 1);
        base = m_count;
        e = '{status: 2'b00, seen: 8'd3, chk_cnt: 1'b1,
              cnt: base + 8'd3};
        issue(8'd0, 8'd3, e, acc);
        wait_done(dc);

        repeat (3) @(negedge clock);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Command-driven initiator for the prescaled `counter` block. It is the side that drives `enable_i`, `write_i` and `c_val` and watches `count_o`. For each accepted command it does three things:
- preloads the counter's internal prescaler phase with a one-cycle write;
- runs the counter until a requested number of `count_o` increments have been observed;
- reports completion, timeout or an illegal count jump.

It sits between a test or host controller and one `counter` instance, one clock domain.

Parameters:
- WIDTH, 8, width of count, load value and step fields; matches the counter's 8-bit count.
- TIMEOUT_CYCLES, 1024, maximum RUN cycles allowed between two observed increments before aborting; must be ≥ 2.

Ports:
- clock_i  input  1  single clock, all state updates on posedge.
- reset_i  input  1  asynchronous, active-high reset.
- cmd_valid_i  input  1  command offered.
- cmd_ready_o  output  1  sequencer can accept a command (high only in IDLE).
- cmd_load_i  input  WIDTH  value written to the counter's prescaler phase.
- cmd_steps_i  input  WIDTH  number of count increments to wait for; 0 means load only.
- enable_o  output  1  to counter `enable_i`.
- write_o  output  1  to counter `write_i`.
- c_val_o  output  WIDTH  to counter `c_val`.
- count_i  input  WIDTH  from counter `count_o`.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  single-cycle pulse when a command finishes.
- status_o  output  2  result code: 00 ok, 01 timeout, 10 jump error; held until the next command is accepted.
- steps_seen_o  output  WIDTH  increments observed for the current or last command.

Behaviour:
- Reset (async, any state):
  - state goes to IDLE;
  - enable_o, write_o, done_o, busy_o = 0;
  - c_val_o, steps_seen_o, status_o = 0;
  - cmd_ready_o = 1 once reset is released.
- States: IDLE, LOAD, RUN, DONE. The encoding lives in the package.
- IDLE:
  - cmd_ready_o = 1; all counter drives are 0.
  - Handshake fires on a posedge with cmd_valid_i & cmd_ready_o.
  - On that edge: latch load and steps, sample count_i into prev_count, clear steps_seen_o and status_o, clear the timeout counter, go to LOAD.
- LOAD (exactly 1 cycle):
  - enable_o = 1, write_o = 1, c_val_o = latched load.
  - Next state is RUN if steps ≠ 0, otherwise DONE with status 00.
- RUN:
  - enable_o = 1, write_o = 0, c_val_o holds its value.
  - Each cycle compare the registered prev_count against count_i:
    - count_i == prev_count: no step; timeout counter +1.
    - count_i == prev_count+1 modulo 2^WIDTH (255→0 is a legal step): steps_seen +1, prev_count updated, timeout counter cleared.
    - any other value: status 10, go to DONE.
  - If steps_seen reaches steps on this cycle, go to DONE with status 00. enable_o is low from the next cycle.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no step, status 01, go to DONE.
  - A step and a timeout in the same cycle: the step wins.
- DONE (1 cycle):
  - done_o = 1, enable_o = 0, cmd_ready_o = 0; go to IDLE.
  - A command offered during DONE is not accepted; it is accepted in IDLE on the following cycle.
- Latency: LOAD is the cycle after acceptance. done_o asserts on the cycle after the final step is observed in RUN.
- busy_o = (state ≠ IDLE).
- Reset mid-command: the command is abandoned, no done_o pulse is emitted, and the counter enable drops immediately.
- Arithmetic: all comparisons and increments are unsigned WIDTH-bit with natural wrap. The timeout counter is clog2(TIMEOUT_CYCLES) bits and saturates at its terminal value.

Decomposition:
- Package `counter_seq_pkg` holds:
  - the state enum (IDLE/LOAD/RUN/DONE);
  - status codes STATUS_OK = 2'b00, STATUS_TIMEOUT = 2'b01, STATUS_JUMP = 2'b10.
- One sub-module, `count_step_detector`: registered prev_count plus the combinational outputs step and jump. It is reusable by other monitors watching a counter output.

Test Plan:
- Load 0, steps 3, real counter with CYCLES_PER_COUNT=8, count starts at 0 → count_o reaches 3; one done_o pulse; status_o=00; steps_seen_o=3; enable_o low from the cycle after done_o.
- Load 7, steps 1, CYCLES_PER_COUNT=8 → first increment visible on the 2nd RUN cycle; done_o within 4 cycles of acceptance; status 00.
- Start count 254 (preset by bench), steps 3 → observes 255, 0, 1 as legal steps; steps_seen_o=3; status 00.
- TIMEOUT_CYCLES=16, bench holds count_i constant at 5, steps 2 → done_o after 15 idle RUN cycles; status_o=01; steps_seen_o=0.
- Bench drives count_i 5→9 during RUN → done_o next cycle; status_o=10; steps_seen_o unchanged.
- Assert reset_i asynchronously mid-RUN with cmd_valid_i held high → enable_o=0 and busy_o=0 immediately, no done_o; after release the command is re-accepted in IDLE and completes normally.
